timer_core: RTL and testbench
=============================

# timer_core

- Programmable down-counting timer: one-shot, periodic and PWM modes.
- Responder on the timer interface bus: samples the testbench driver's `mode`, `prescaler`, `reload_val`, `compare_val` and `start`; returns `timeout`, `pwm_out` and `current_count` to the driver and monitor.
- Single clock domain. All outputs registered.

## Interface
- `CNT_W`, 32: width of reload, compare and count.
- `PRE_W`, 16: width of prescaler.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `mode`  in  2  0 = one-shot, 1 = periodic, 2 = PWM, 3 = reserved (never starts).
- `prescaler`  in  PRE_W  tick divider; one tick every `prescaler+1` clocks.
- `reload_val`  in  CNT_W  count loaded at start and at each auto-reload.
- `compare_val`  in  CNT_W  PWM threshold.
- `start`  in  1  level enable: high = run, low = stop.
- `timeout`  out  1  one-clock pulse on expiry.
- `pwm_out`  out  1  PWM output.
- `current_count`  out  CNT_W  live counter value.

## Operation
- States:
  - IDLE, RUN, DONE.
  - Reset forces IDLE, `current_count`=0, prescale counter=0, `timeout`=0, `pwm_out`=0.
- IDLE -> RUN when `start`=1 and `mode`!=3.
  - Latch `mode` and `prescaler`.
  - Load count = `reload_val`; clear prescale counter.
  - `mode`=3 with `start`=1: stay IDLE, outputs unchanged.
- RUN:
  - Prescale counter increments each clock.
  - When it equals the latched prescaler, a tick occurs and the prescale counter returns to 0.
- On tick with count != 0: count decrements by 1.
- On tick with count == 0:
  - Assert `timeout` for exactly one clock.
  - One-shot: go to DONE; count holds 0.
  - Periodic / PWM: count reloads from the current `reload_val` (sampled at the reload edge); stay in RUN.
- RUN with `start`=0 -> IDLE.
  - Count and prescale counter freeze (no reset).
  - `pwm_out` drops to 0.
  - A new start reloads the count from `reload_val`.
- DONE: holds until `start`=0, then -> IDLE. Re-triggering requires `start` low then high.
- `timeout` is 0 in every cycle except the expiry pulse.
- `pwm_out` (registered) = 1 iff state RUN, latched mode = 2 and next count < `compare_val`.
  - `compare_val`=0: always low.
  - `compare_val` > `reload_val`: always high while running.
  - `compare_val` is live, not latched.
- Changes to `mode` or `prescaler` while RUN are ignored until the next IDLE -> RUN.
- Arithmetic is unsigned, with no wrap below 0.
  - `reload_val`=0 in periodic mode: `timeout` on every tick.
  - Prescale counter is PRE_W wide; `prescaler`=16'hFFFF gives 65536 clocks per tick.

## Timing
- Start latency: `start` sampled high at edge E0 -> `current_count`=`reload_val` visible after E0.
- Next-state logic uses the registered prescale and count values, so the first tick occurs at E(prescaler+1).
- Periodic period: (`reload_val`+1)×(`prescaler`+1) clocks between `timeout` rising edges.
  - Example: reload 3, prescaler 0. Counts 3, 2, 1, 0 after E0–E3; `timeout`=1 after E4 with count=3; repeats every 4 clocks.
- One-shot: same first-pulse timing as periodic, then DONE with count 0.
- `pwm_out` updates on the same edge as `current_count`.
- Stop: `start` sampled low at edge Es -> IDLE, `pwm_out`=0 after Es.
  - No `timeout` at Es, even if Es would have been a terminal tick.
- Reset mid-run: outputs take reset values after the reset edge, regardless of state. A pending `timeout` is suppressed.
- Simultaneous terminal tick and `start` falling: stop wins; no pulse, count frozen at 0.

## Test plan
- Reset: hold `rst` 3 clocks while `start`=1, mode 1 -> `timeout`=0, `pwm_out`=0, `current_count`=0 throughout; the timer starts on the first edge after `rst` falls.
- One-shot, reload 3, prescaler 0:
  - Exactly one `timeout` pulse, 4 clocks after the start edge, then DONE with count 0 for 20 further clocks.
  - Dropping and re-raising `start` produces a second pulse.
- Periodic, reload 2, prescaler 1:
  - `timeout` pulses every 6 clocks for 5 periods.
  - Changing `reload_val` to 4 mid-run makes the following period 10 clocks.
- PWM, reload 9, compare 3, prescaler 0:
  - Period 10 clocks, `pwm_out` high 3 clocks per period.
  - compare 0 -> constant low; compare 12 -> constant high.
- Stop/resume: drop `start` while count=5 -> count holds 5 and `pwm_out`=0; re-raise -> count = `reload_val`.
- Edge cases:
  - Periodic, reload 0, prescaler 0: `timeout` high every clock.
  - Mode 3 with `start`=1: state stays IDLE, `current_count` unchanged.
  - Terminal tick coinciding with `start` falling: no pulse.

Source files
------------

// File: rtl/timer_core.sv
// Programmable down-counting timer with one-shot, periodic and PWM modes.
// Prescaled tick, registered outputs, synchronous active-high reset.
`timescale 1ns/1ps
module timer_core #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned PRE_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [PRE_W-1:0] prescaler,
  input  logic [CNT_W-1:0] reload_val,
  input  logic [CNT_W-1:0] compare_val,
  input  logic             start,
  output logic             timeout,
  output logic             pwm_out,
  output logic [CNT_W-1:0] current_count
);

  localparam logic [1:0] MODE_ONESHOT = 2'd0;
  localparam logic [1:0] MODE_PWM     = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [PRE_W-1:0] psc_q, psc_d;
  logic [1:0]       mode_q, mode_d;
  logic             to_q, to_d;
  logic             pwm_q, pwm_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      psc_q   <= '0;
      mode_q  <= MODE_ONESHOT;
      to_q    <= 1'b0;
      pwm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      psc_q   <= psc_d;
      mode_q  <= mode_d;
      to_q    <= to_d;
      pwm_q   <= pwm_d;
    end
  end

  // Next-state: start/stop control, prescaled tick, expiry and reload.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    psc_d   = psc_q;
    mode_d  = mode_q;
    to_d    = 1'b0;
    pwm_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (mode != MODE_RSVD)) begin
          state_d = S_RUN;
          mode_d  = mode;
          psc_d   = prescaler;
          cnt_d   = reload_val;
          pre_d   = '0;
        end
      end
      S_RUN: begin
        // Stopping freezes count and prescaler and beats a coincident expiry.
        if (!start) begin
          state_d = S_IDLE;
        end else if (pre_q == psc_q) begin
          pre_d = '0;
          if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            to_d = 1'b1;
            if (mode_q == MODE_ONESHOT) begin
              state_d = S_DONE;
            end else begin
              cnt_d = reload_val;
            end
          end
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
      end
      S_DONE: begin
        if (!start) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    pwm_d = (state_d == S_RUN) && (mode_d == MODE_PWM) && (cnt_d < compare_val);
  end

  assign timeout       = to_q;
  assign pwm_out       = pwm_q;
  assign current_count = cnt_q;

endmodule

// File: tb/tb_timer_core.sv
// Self-checking bench for timer_core: per-scenario tasks, expected outputs
// queued before each clock edge and compared after it.
`timescale 1ns/1ps
module tb_timer_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic [15:0] prescaler;
  logic [31:0] reload_val;
  logic [31:0] compare_val;
  logic        start;
  logic        timeout;
  logic        pwm_out;
  logic [31:0] current_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        to;
    logic        pwm;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  timer_core #(.CNT_W(32), .PRE_W(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .mode          (mode),
    .prescaler     (prescaler),
    .reload_val    (reload_val),
    .compare_val   (compare_val),
    .start         (start),
    .timeout       (timeout),
    .pwm_out       (pwm_out),
    .current_count (current_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_out();
    start = 1'b0;
    cyc();
    cyc();
  endtask

  // Closed-form count after edge k of a run started at edge 0.
  function automatic logic [31:0] f_cnt(int k, int r, int p, bit os);
    int t;
    if (k == 0) return 32'(r);
    t = k / (p + 1);
    if (os && t >= r + 1) return 32'd0;
    return 32'(r - (t % (r + 1)));
  endfunction

  function automatic logic f_to(int k, int r, int p, bit os);
    int t;
    if (k == 0 || (k % (p + 1)) != 0) return 1'b0;
    t = k / (p + 1);
    if (os) return (t == r + 1);
    return ((t % (r + 1)) == 0);
  endfunction

  task automatic test_reset();
    exp_t e, g;
    rst = 1'b1; start = 1'b1; mode = 2'd1; prescaler = '0;
    reload_val = 32'd5; compare_val = '0;
    for (int s = 0; s < 4; s++) begin
      if (s == 3) rst = 1'b0;
      e.to = 1'b0; e.pwm = 1'b0;
      e.cnt = (s == 3) ? 32'd5 : 32'd0;
      e.tag = (s == 3) ? "reset_release" : "reset_hold";
      exp_q.push_back(e);
      cyc();
      g = exp_q.pop_front();
      total++;
      if (timeout !== g.to) begin bad++; $display("FAIL %s s=%0d timeout got=%b exp=%b", g.tag, s, timeout, g.to); end
      total++;
      if (pwm_out !== g.pwm) begin bad++; $display("FAIL %s s=%0d pwm_out got=%b exp=%b", g.tag, s, pwm_out, g.pwm); end
      total++;
      if (current_count !== g.cnt) begin bad++; $display("FAIL %s s=%0d count got=%0d exp=%0d", g.tag, s, current_count, g.cnt); end
    end
    idle_out();
  endtask

  task automatic test_one_shot();
    exp_t e, g;
    int pulses = 0;
    mode = 2'd0; prescaler = 16'd0; reload_val = 32'd3; compare_val = 32'd0;
    for (int s = 0; s < 34; s++) begin
      start = (s != 25);
      if (s <= 24) begin
        e.to = f_to(s, 3, 0, 1'b1); e.cnt = f_cnt(s, 3, 0, 1'b1);
      end else if (s == 25) begin
        e.to = 1'b0; e.cnt = 32'd0;
      end else begin
        e.to = f_to(s - 26, 3, 0, 1'b1); e.cnt = f_cnt(s - 26, 3, 0, 1'b1);
      end
      e.pwm = 1'b0; e.tag = "one_shot";
      exp_q.push_back(e);
      cyc();
      g = exp_q.pop_front();
      if (timeout === 1'b1) pulses++;
      total++;
      if (timeout !== g.to) begin bad++; $display("FAIL %s s=%0d timeout got=%b exp=%b", g.tag, s, timeout, g.to); end
      total++;
      if (pwm_out !== g.pwm) begin bad++; $display("FAIL %s s=%0d pwm_out got=%b exp=%b", g.tag, s, pwm_out, g.pwm); end
      total++;
      if (current_count !== g.cnt) begin bad++; $display("FAIL %s s=%0d count got=%0d exp=%0d", g.tag, s, current_count, g.cnt); end
    end
    total++;
    if (pulses !== 2) begin bad++; $display("FAIL one_shot_pulses got=%0d exp=2", pulses); end
    idle_out();
  endtask

  task automatic test_periodic();
    exp_t e, g;
    mode = 2'd1; prescaler = 16'd1; reload_val = 32'd2; compare_val = 32'd0;
    start = 1'b1;
    for (int s = 0; s < 51; s++) begin
      if (s == 33) reload_val = 32'd4;
      if (s <= 36) begin
        e.to = f_to(s, 2, 1, 1'b0);
        e.cnt = (s == 36) ? 32'd4 : f_cnt(s, 2, 1, 1'b0);
      end else begin
        e.to = f_to(s - 36, 4, 1, 1'b0); e.cnt = f_cnt(s - 36, 4, 1, 1'b0);
      end
      e.pwm = 1'b0; e.tag = "periodic";
      exp_q.push_back(e);
      cyc();
      g = exp_q.pop_front();
      total++;
      if (timeout !== g.to) begin bad++; $display("FAIL %s s=%0d timeout got=%b exp=%b", g.tag, s, timeout, g.to); end
      total++;
      if (pwm_out !== g.pwm) begin bad++; $display("FAIL %s s=%0d pwm_out got=%b exp=%b", g.tag, s, pwm_out, g.pwm); end
      total++;
      if (current_count !== g.cnt) begin bad++; $display("FAIL %s s=%0d count got=%0d exp=%0d", g.tag, s, current_count, g.cnt); end
    end
    idle_out();
  endtask

  task automatic test_pwm();
    exp_t e, g;
    int unsigned cmp;
    mode = 2'd2; prescaler = 16'd0; reload_val = 32'd9; start = 1'b1;
    for (int s = 0; s < 60; s++) begin
      cmp = (s < 20) ? 3 : ((s < 40) ? 0 : 12);
      compare_val = 32'(cmp);
      e.to = f_to(s, 9, 0, 1'b0);
      e.cnt = f_cnt(s, 9, 0, 1'b0);
      e.pwm = (e.cnt < 32'(cmp));
      e.tag = "pwm";
      exp_q.push_back(e);
      cyc();
      g = exp_q.pop_front();
      total++;
      if (timeout !== g.to) begin bad++; $display("FAIL %s s=%0d timeout got=%b exp=%b", g.tag, s, timeout, g.to); end
      total++;
      if (pwm_out !== g.pwm) begin bad++; $display("FAIL %s s=%0d pwm_out got=%b exp=%b", g.tag, s, pwm_out, g.pwm); end
      total++;
      if (current_count !== g.cnt) begin bad++; $display("FAIL %s s=%0d count got=%0d exp=%0d", g.tag, s, current_count, g.cnt); end
    end
    idle_out();
  endtask

  task automatic test_stop_resume();
    exp_t e, g;
    mode = 2'd2; prescaler = 16'd0; reload_val = 32'd9; compare_val = 32'd12;
    for (int s = 0; s < 9; s++) begin
      start = (s <= 4 || s == 8);
      if (s == 8) reload_val = 32'd7;
      e.to = 1'b0;
      if (s <= 4) begin
        e.cnt = f_cnt(s, 9, 0, 1'b0); e.pwm = 1'b1;
      end else if (s <= 7) begin
        e.cnt = 32'd5; e.pwm = 1'b0;
      end else begin
        e.cnt = 32'd7; e.pwm = 1'b1;
      end
      e.tag = "stop_resume";
      exp_q.push_back(e);
      cyc();
      g = exp_q.pop_front();
      total++;
      if (timeout !== g.to) begin bad++; $display("FAIL %s s=%0d timeout got=%b exp=%b", g.tag, s, timeout, g.to); end
      total++;
      if (pwm_out !== g.pwm) begin bad++; $display("FAIL %s s=%0d pwm_out got=%b exp=%b", g.tag, s, pwm_out, g.pwm); end
      total++;
      if (current_count !== g.cnt) begin bad++; $display("FAIL %s s=%0d count got=%0d exp=%0d", g.tag, s, current_count, g.cnt); end
    end
    idle_out();
  endtask

  // Reload 0 every clock, reserved mode, and stop racing a terminal tick.
  task automatic test_edges();
    exp_t e, g;
    prescaler = 16'd0; compare_val = 32'd0;
    for (int s = 0; s < 27; s++) begin
      e.to = 1'b0; e.pwm = 1'b0; e.cnt = 32'd0;
      if (s <= 9) begin
        mode = 2'd1; reload_val = 32'd0; start = 1'b1;
        e.to = f_to(s, 0, 0, 1'b0); e.cnt = f_cnt(s, 0, 0, 1'b0);
        e.tag = "reload_zero";
      end else if (s == 10) begin
        start = 1'b0; e.tag = "reload_zero_stop";
      end else if (s <= 13) begin
        reload_val = 32'd20; start = (s != 13);
        e.cnt = (s == 11) ? 32'd20 : 32'd19; e.tag = "prime";
      end else if (s <= 18) begin
        mode = 2'd3; reload_val = 32'd55; start = 1'b1;
        e.cnt = 32'd19; e.tag = "mode3";
      end else if (s == 19) begin
        mode = 2'd1; e.cnt = 32'd55; e.tag = "mode3_exit";
      end else if (s == 20) begin
        start = 1'b0; e.cnt = 32'd55; e.tag = "mode3_exit_stop";
      end else if (s <= 23) begin
        reload_val = 32'd2; start = 1'b1;
        e.cnt = 32'(23 - s); e.tag = "stop_race_run";
      end else begin
        start = 1'b0; e.tag = "stop_race";
      end
      exp_q.push_back(e);
      cyc();
      g = exp_q.pop_front();
      total++;
      if (timeout !== g.to) begin bad++; $display("FAIL %s s=%0d timeout got=%b exp=%b", g.tag, s, timeout, g.to); end
      total++;
      if (pwm_out !== g.pwm) begin bad++; $display("FAIL %s s=%0d pwm_out got=%b exp=%b", g.tag, s, pwm_out, g.pwm); end
      total++;
      if (current_count !== g.cnt) begin bad++; $display("FAIL %s s=%0d count got=%0d exp=%0d", g.tag, s, current_count, g.cnt); end
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_periodic();
    test_pwm();
    test_stop_resume();
    test_edges();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
